// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared PS/2 definitions for the host transmitter and the
//            keyboard receiver: controller state encoding, protocol timing
//            constants and a microsecond-to-cycle helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Host-to-device transmit controller states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  // Protocol timing defaults (microseconds) and frame geometry.
  localparam int C_INHIBIT_US = 100;
  localparam int C_TIMEOUT_US = 2000;
  // start + 8 data + parity + stop (+ device ACK slot handled separately)
  localparam int C_FRAME_BITS = 11;

  // Whole cycles per microsecond times the interval length.
  function automatic int us_to_cycles(input int clk_freq_hz, input int us);
    return (clk_freq_hz / 1_000_000) * us;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_sync_edge
// Purpose  : Two-flop synchronizer for an asynchronous PS/2 pad level plus a
//            falling-edge detector on the synchronized value.
// Ports    : CLK      in  system clock
//            RST_N    in  asynchronous active-low reset (flops reset to 1,
//                         the idle level of an open-drain PS/2 line)
//            i_async  in  raw pad level
//            o_sync   out synchronized level
//            o_fall   out one-cycle pulse: sync = 0 and previous = 1
// Revision : 1.0 - initial release
// ============================================================================
module ps2_sync_edge (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter. Inhibits the bus,
//            issues a start bit, shifts out 8 data bits LSB first with odd
//            parity and a stop bit on the device clock, checks the device
//            ACK and waits for the bus to return idle.
// Ports    : CLK         in  system clock
//            RST_N       in  asynchronous active-low reset
//            WR          in  one-cycle strobe, starts sending DIN (IDLE only)
//            DIN[7:0]    in  command byte
//            PS2CLK_IN   in  raw PS/2 clock pad level (asynchronous)
//            PS2DATA_IN  in  raw PS/2 data pad level (asynchronous)
//            PS2CLK_OE   out 1 = pull PS/2 clock low, 0 = release
//            PS2DATA_OE  out 1 = pull PS/2 data low, 0 = release
//            BUSY        out transfer in progress
//            DONE        out one-cycle pulse, acknowledged transfer
//            ERR         out one-cycle pulse, timeout or NACK
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = C_INHIBIT_US,
  parameter int TIMEOUT_US  = C_TIMEOUT_US
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WR,
  input  logic [7:0] DIN,
  input  logic       PS2CLK_IN,
  input  logic       PS2DATA_IN,
  output logic       PS2CLK_OE,
  output logic       PS2DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int C_INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int C_TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int C_CNT_MAX = (C_TIMEOUT_CYCLES > C_INHIBIT_CYCLES) ?
                             C_TIMEOUT_CYCLES : C_INHIBIT_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam int C_SHIFT_W = C_FRAME_BITS - 1;

  localparam logic [C_CNT_W-1:0] C_INH_LAST = C_CNT_W'(C_INHIBIT_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_TO_LAST  = C_CNT_W'(C_TIMEOUT_CYCLES - 1);
  // Index of the last host-driven bit (stop); the slot after it is the ACK.
  localparam logic [3:0]         C_LAST_TX_BIT = 4'(C_FRAME_BITS - 2);

  // --------------------------------------------------------------------------
  // Pad synchronizers
  // --------------------------------------------------------------------------
  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_async (PS2CLK_IN),
    .o_sync  (w_clk_sync),
    .o_fall  (w_clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_async (PS2DATA_IN),
    .o_sync  (w_data_sync),
    .o_fall  (w_data_fall_unused)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  ps2_state_e           r_state;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_SHIFT_W-1:0] r_shift;
  logic [3:0]           r_bitcnt;
  logic                 r_clk_oe;
  logic                 r_data_oe;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  ps2_state_e           w_state;
  logic [C_CNT_W-1:0]   w_cnt;
  logic [C_SHIFT_W-1:0] w_shift;
  logic [3:0]           w_bitcnt;
  logic                 w_clk_oe;
  logic                 w_data_oe;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_err;
  logic [C_CNT_W-1:0]   w_cnt_run;
  logic                 w_to_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_shift   <= w_shift;
      r_bitcnt  <= w_bitcnt;
      r_clk_oe  <= w_clk_oe;
      r_data_oe <= w_data_oe;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are decoded from the next state
  // and registered, so the pads never see decode glitches.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_shift   = r_shift;
    w_bitcnt  = r_bitcnt;
    w_data_oe = r_data_oe;
    w_done    = 1'b0;
    w_err     = 1'b0;

    // Shared timeout counter: reload on a device falling edge, else count.
    w_cnt_run = w_clk_fall ? '0 : r_cnt + C_CNT_W'(1);
    w_to_hit  = ~w_clk_fall && (r_cnt == C_TO_LAST);

    case (r_state)
      ST_IDLE: begin
        w_data_oe = 1'b0;
        if (WR) begin
          w_state  = ST_INHIBIT;
          w_shift  = {1'b1, ~^DIN, DIN};
          w_bitcnt = '0;
          w_cnt    = '0;
        end
      end

      ST_INHIBIT: begin
        if (r_cnt == C_INH_LAST) begin
          w_state   = ST_START;
          w_cnt     = '0;
          w_data_oe = 1'b1;
        end else begin
          w_cnt = r_cnt + C_CNT_W'(1);
        end
      end

      ST_START: begin
        // Clock released, start bit (data low) held until the first edge.
        w_state   = ST_SEND;
        w_cnt     = '0;
        w_data_oe = 1'b1;
      end

      ST_SEND: begin
        w_cnt = w_cnt_run;
        if (w_clk_fall) begin
          w_data_oe = ~r_shift[0];
          w_shift   = {1'b0, r_shift[C_SHIFT_W-1:1]};
          w_bitcnt  = r_bitcnt + 4'd1;
          if (r_bitcnt == C_LAST_TX_BIT) begin
            w_state = ST_ACK;
          end
        end else if (w_to_hit) begin
          w_state   = ST_IDLE;
          w_cnt     = '0;
          w_data_oe = 1'b0;
          w_err     = 1'b1;
        end
      end

      ST_ACK: begin
        w_cnt = w_cnt_run;
        if (w_clk_fall) begin
          if (!w_data_sync) begin
            w_state = ST_WAIT_IDLE;
          end else begin
            // Device left data high in the ACK slot: NACK.
            w_state   = ST_IDLE;
            w_cnt     = '0;
            w_data_oe = 1'b0;
            w_err     = 1'b1;
          end
        end else if (w_to_hit) begin
          w_state   = ST_IDLE;
          w_cnt     = '0;
          w_data_oe = 1'b0;
          w_err     = 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (w_clk_sync && w_data_sync) begin
          w_state = ST_IDLE;
          w_cnt   = '0;
          w_done  = 1'b1;
        end else begin
          w_cnt = w_cnt_run;
          if (w_to_hit) begin
            w_state   = ST_IDLE;
            w_cnt     = '0;
            w_data_oe = 1'b0;
            w_err     = 1'b1;
          end
        end
      end

      default: begin
        w_state   = ST_IDLE;
        w_cnt     = '0;
        w_data_oe = 1'b0;
      end
    endcase

    // Data joins the clock inhibit only in the last inhibit cycle.
    if (w_state == ST_INHIBIT) begin
      w_data_oe = (w_cnt == C_INH_LAST);
    end

    w_clk_oe = (w_state == ST_INHIBIT);
    // BUSY stays up through the DONE/ERR cycle and drops one cycle later.
    w_busy   = (w_state != ST_IDLE) | w_done | w_err;
  end

  assign PS2CLK_OE  = r_clk_oe;
  assign PS2DATA_OE = r_data_oe;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign ERR        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with an open-drain PS/2
//            device model. Expected frames and outcomes are queued at
//            stimulus time; monitors pop and compare when the device
//            captures a frame or the DUT pulses DONE/ERR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int CLK_HALF_NS = 10;     // 50 MHz
  localparam int DEV_HALF_NS = 4000;   // device clock half period
  localparam int INHIBIT_CYC = 50;     // 1 us at 50 MHz
  localparam int RES_DONE    = 1;
  localparam int RES_ERR     = 2;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR    = 1'b0;
  logic [7:0] DIN   = 8'h00;
  logic       PS2CLK_OE;
  logic       PS2DATA_OE;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2clk_line;
  logic ps2data_line;

  // Open-drain wired-AND bus with pull-ups.
  assign ps2clk_line  = ~(PS2CLK_OE  | dev_clk_low);
  assign ps2data_line = ~(PS2DATA_OE | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ (50_000_000),
    .INHIBIT_US  (1),
    .TIMEOUT_US  (20)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .WR         (WR),
    .DIN        (DIN),
    .PS2CLK_IN  (ps2clk_line),
    .PS2DATA_IN (ps2data_line),
    .PS2CLK_OE  (PS2CLK_OE),
    .PS2DATA_OE (PS2DATA_OE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #(CLK_HALF_NS) CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_frame_q[$];
  logic [9:0] obs_frame_q[$];
  int         exp_res_q[$];
  event       frame_ev;
  realtime    t_last_fall = 0.0;
  realtime    t_err       = 0.0;
  int         pulse_count = 0;
  bit         busy_chk    = 1'b0;
  int         res_e;
  logic [9:0] obs_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome monitor: every DONE/ERR pulse is matched against the queue.
  always @(negedge CLK) begin
    if (busy_chk) begin
      check("busy_after_pulse", {31'd0, BUSY}, 0);
      busy_chk = 1'b0;
    end
    if (DONE || ERR) begin
      pulse_count++;
      check("busy_at_pulse", {31'd0, BUSY}, 1);
      check("done_err_exclusive", {31'd0, DONE & ERR}, 0);
      if (exp_res_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, DONE, ERR}, 0);
      end else begin
        res_e = exp_res_q.pop_front();
        check("result", DONE ? RES_DONE : RES_ERR, res_e);
      end
      if (ERR) begin
        t_err = $realtime;
        check("oe_released_on_err", {30'd0, PS2CLK_OE, PS2DATA_OE}, 0);
      end
      busy_chk = 1'b1;
    end
  end

  // Frame monitor: compares each frame the device captured.
  always begin
    @(frame_ev);
    while (obs_frame_q.size() > 0) begin
      obs_f = obs_frame_q.pop_front();
      if (exp_frame_q.size() == 0) check("unexpected_frame", {22'd0, obs_f}, 0);
      else check("frame_bits", {22'd0, obs_f}, {22'd0, exp_frame_q.pop_front()});
    end
  end

  // Device model: waits for the host start condition, clocks n_edges falling
  // edges, samples host bits on each rising edge, drives ACK if asked.
  task automatic dev_xfer(input int n_edges, input bit ack);
    logic [9:0] cap;
    int k;
    cap = '0;
    k = 0;
    while (!(PS2CLK_OE == 1'b0 && ps2data_line == 1'b0) && k < 20000) begin
      #(2 * CLK_HALF_NS);
      k++;
    end
    if (!(PS2CLK_OE == 1'b0 && ps2data_line == 1'b0)) begin
      check("dev_start_seen", {30'd0, PS2CLK_OE, ps2data_line}, 0);
      return;
    end
    #(DEV_HALF_NS);
    check("start_bit", {31'd0, ps2data_line}, 0);
    for (int i = 1; i <= n_edges; i++) begin
      dev_clk_low = 1'b1;
      t_last_fall = $realtime;
      #(DEV_HALF_NS);
      dev_clk_low = 1'b0;
      if (i <= 10) cap[i-1] = ps2data_line;
      if (i == 10) begin
        #(DEV_HALF_NS / 2);
        dev_data_low = ack;
        #(DEV_HALF_NS / 2);
      end else begin
        #(DEV_HALF_NS);
      end
    end
    dev_data_low = 1'b0;
    if (n_edges >= 10) begin
      obs_frame_q.push_back(cap);
      -> frame_ev;
    end
  endtask

  // Issues WR and checks latency, inhibit length and data-join timing.
  task automatic issue_wr(input logic [7:0] din);
    int n_clk;
    int n_both;
    @(negedge CLK);
    DIN = din;
    WR  = 1'b1;
    @(posedge CLK);
    #1;
    check("wr_to_clk_oe_latency", {31'd0, PS2CLK_OE}, 1);
    check("busy_after_wr", {31'd0, BUSY}, 1);
    @(negedge CLK);
    WR = 1'b0;
    n_clk  = 0;
    n_both = 0;
    while (PS2CLK_OE && n_clk < 1000) begin
      n_clk++;
      if (PS2DATA_OE) n_both++;
      @(negedge CLK);
    end
    check("inhibit_cycles", n_clk, INHIBIT_CYC);
    check("inhibit_data_join", n_both, 1);
    check("start_data_oe", {31'd0, PS2DATA_OE}, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    check("busy_falls", {31'd0, BUSY}, 0);
    repeat (20) @(negedge CLK);
  endtask

  task automatic run_xfer(input logic [7:0] din, input logic [9:0] frame,
                          input int n_edges, input bit ack, input int res);
    if (n_edges >= 10) exp_frame_q.push_back(frame);
    exp_res_q.push_back(res);
    fork
      dev_xfer(n_edges, ack);
      issue_wr(din);
    join
    wait_idle();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    realtime dt;
    int snap;

    // Reset state
    #35;
    check("rst_clk_oe",  {31'd0, PS2CLK_OE},  0);
    check("rst_data_oe", {31'd0, PS2DATA_OE}, 0);
    check("rst_busy",    {31'd0, BUSY},       0);
    check("rst_done_err", {30'd0, DONE, ERR}, 0);
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);

    // Frame = {stop, parity, D7..D0}; parity values counted by hand.
    run_xfer(8'hED, 10'h3ED, 11, 1'b1, RES_DONE);  // 6 ones -> parity 1
    run_xfer(8'h00, 10'h300, 11, 1'b1, RES_DONE);  // 0 ones -> parity 1
    run_xfer(8'h01, 10'h201, 11, 1'b1, RES_DONE);  // 1 one  -> parity 0

    // NACK: device leaves data high in the ACK slot.
    run_xfer(8'hED, 10'h3ED, 11, 1'b0, RES_ERR);

    // Device stops clocking after the 4th edge.
    run_xfer(8'hA5, 10'h000, 4, 1'b1, RES_ERR);
    dt = t_err - t_last_fall;
    check("timeout_window", {31'd0, (dt >= 20000.0 && dt <= 20200.0)}, 1);
    check("lines_released", {30'd0, PS2CLK_OE, PS2DATA_OE}, 0);
    run_xfer(8'hFF, 10'h3FF, 11, 1'b1, RES_DONE);  // 8 ones -> parity 1

    // Second WR during a transfer is ignored.
    exp_frame_q.push_back(10'h3ED);
    exp_res_q.push_back(RES_DONE);
    fork
      dev_xfer(11, 1'b1);
      begin
        issue_wr(8'hED);
        #30000;
        @(negedge CLK);
        DIN = 8'h55;
        WR  = 1'b1;
        @(negedge CLK);
        WR  = 1'b0;
        DIN = 8'h00;
      end
    join
    wait_idle();

    // Asynchronous reset in the middle of SEND.
    snap = pulse_count;
    fork
      dev_xfer(5, 1'b1);
      begin
        issue_wr(8'hED);
        #(DEV_HALF_NS * 2 * 3);
        @(negedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("async_rst_clk_oe",  {31'd0, PS2CLK_OE},  0);
        check("async_rst_data_oe", {31'd0, PS2DATA_OE}, 0);
        check("async_rst_busy",    {31'd0, BUSY},       0);
      end
    join
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    #40000;
    check("no_pulse_after_reset", pulse_count, snap);
    check("idle_after_reset", {29'd0, BUSY, PS2CLK_OE, PS2DATA_OE}, 0);

    check("results_left", exp_res_q.size(), 0);
    check("frames_left", exp_frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
